// File: rtl/qr_pkg.sv
// Shared types and constants for the 3x3 QR rotation sequencer.
//   state_e    : sequencer FSM states
//   rot_mode_e : rotation-unit operating mode
//   op_t       : one scheduled rotation-unit operation
//   elem_addr  : builds {bank, row*3+col} element-store addresses
package qr_pkg;

    localparam int QR_ADDR_W = 5;
    localparam int NUM_OPS   = 17;
    localparam int OP_W      = 5;

    localparam logic BANK_R  = 1'b0;
    localparam logic BANK_QT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        TRANSPOSE,
        DONE
    } state_e;

    typedef enum logic {
        VECTOR = 1'b0,
        ROTATE = 1'b1
    } rot_mode_e;

    typedef struct packed {
        rot_mode_e              mode;
        logic [QR_ADDR_W-1:0]   addr_a;
        logic [QR_ADDR_W-1:0]   addr_b;
        logic                   final_q;  // Q^T op of the last rotation
    } op_t;

    function automatic logic [QR_ADDR_W-1:0] elem_addr(input logic bank, input int row,
                                                       input int col);
        logic [3:0] idx;
        idx = 4'(row * 3 + col);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/qr_schedule_rom.sv
// Combinational schedule lookup: op index (0..16) -> operation descriptor.
//   op_idx : in  op counter
//   op     : out mode, operand addresses, final-rotation Q^T flag
// Rotations (p,q,c) = (0,1,0), (0,2,0), (1,2,1). Each rotation is one VECTOR
// on column c, ROTATEs on R columns c+1..2, then ROTATEs on Q^T columns 0..2.
module qr_schedule_rom
    import qr_pkg::*;
(
    input  logic [OP_W-1:0] op_idx,
    output op_t             op
);

    int p, q, c, j;  // rotation rows/pivot column and op index within the rotation

    always_comb begin
        p = 0;
        q = 1;
        c = 0;
        j = int'(op_idx);
        if (op_idx >= 5'd12) begin
            p = 1; q = 2; c = 1; j = int'(op_idx) - 12;
        end else if (op_idx >= 5'd6) begin
            p = 0; q = 2; c = 0; j = int'(op_idx) - 6;
        end

        op = '0;
        if (int'(op_idx) >= NUM_OPS) begin
            op = '0;
        end else if (j == 0) begin
            op.mode   = VECTOR;
            op.addr_a = elem_addr(BANK_R, p, c);
            op.addr_b = elem_addr(BANK_R, q, c);
        end else if (j <= 2 - c) begin
            op.mode   = ROTATE;
            op.addr_a = elem_addr(BANK_R, p, c + j);
            op.addr_b = elem_addr(BANK_R, q, c + j);
        end else begin
            op.mode    = ROTATE;
            op.addr_a  = elem_addr(BANK_QT, p, j - (3 - c));
            op.addr_b  = elem_addr(BANK_QT, q, j - (3 - c));
            // the last rotation's Q^T ops are the last three in the schedule
            op.final_q = (int'(op_idx) >= NUM_OPS - 3);
        end
    end

endmodule

// File: rtl/qr_rotation_sequencer.sv
// Sequences the 17 Givens-rotation ops of a 3x3 QR decomposition onto the
// shared rotation unit, drives store write-back, then triggers Q^T readout.
//   CLK, RST         : clock, synchronous active-high reset
//   start            : begin a decomposition (honoured only when idle)
//   rot_valid/ready  : op handshake with the rotation unit
//   rot_mode, rot_addr_a/b : op mode and operand addresses
//   rot_done         : result-available pulse from the rotation unit
//   wr_en, wr_addr_a/b     : element-store write-back
//   q_init           : store loads identity into the Q^T bank
//   valid_transpose  : final-rotation Q^T pair on store outputs
//   start_transpose  : Q_Transpose readout enable
//   busy, done       : sequence status / completion pulse
module qr_rotation_sequencer
    import qr_pkg::*;
#(
    parameter int WORDLEN            = 16,
    parameter int FRACTION_WIDTH     = 12,
    parameter int MATRIX_ELEMENT_NUM = 9,
    parameter int ADDR_W             = $clog2(MATRIX_ELEMENT_NUM) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              rot_valid,
    input  logic              rot_ready,
    output logic              rot_mode,
    output logic [ADDR_W-1:0] rot_addr_a,
    output logic [ADDR_W-1:0] rot_addr_b,
    input  logic              rot_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic              q_init,
    output logic              valid_transpose,
    output logic              start_transpose,
    output logic              busy,
    output logic              done
);

    localparam int TCNT_W = (MATRIX_ELEMENT_NUM > 1) ? $clog2(MATRIX_ELEMENT_NUM) : 1;

    // The schedule only fits this address layout; word format must leave an integer bit.
    if (ADDR_W != QR_ADDR_W || FRACTION_WIDTH >= WORDLEN) begin : g_bad_params
        $error("qr_rotation_sequencer: unsupported parameter set");
    end

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              q_init_q, q_init_d;
    op_t               op;
    logic              op_active;

    qr_schedule_rom u_rom (
        .op_idx (op_q),
        .op     (op)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            op_q     <= '0;
            tcnt_q   <= '0;
            q_init_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tcnt_q   <= tcnt_d;
            q_init_q <= q_init_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tcnt_d   = tcnt_q;
        q_init_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ISSUE;
                    op_d     = '0;
                    q_init_d = 1'b1;  // registered so it lasts only the first ISSUE cycle
                end
            end
            ISSUE: if (rot_ready) state_d = WAIT;
            WAIT:  if (rot_done)  state_d = WRITE;
            WRITE: begin
                if (op_q == OP_W'(NUM_OPS - 1)) begin
                    state_d = TRANSPOSE;
                    tcnt_d  = '0;
                end else begin
                    state_d = ISSUE;
                    op_d    = op_q + 1'b1;
                end
            end
            TRANSPOSE: begin
                if (tcnt_q == TCNT_W'(MATRIX_ELEMENT_NUM - 1)) state_d = DONE;
                else tcnt_d = tcnt_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                op_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; addresses are zero outside an op.
    always_comb begin
        op_active       = (state_q == ISSUE) || (state_q == WAIT) || (state_q == WRITE);
        rot_valid       = (state_q == ISSUE);
        rot_mode        = op_active && (op.mode == ROTATE);
        rot_addr_a      = op_active ? ADDR_W'(op.addr_a) : '0;
        rot_addr_b      = op_active ? ADDR_W'(op.addr_b) : '0;
        wr_en           = (state_q == WRITE);
        wr_addr_a       = op_active ? ADDR_W'(op.addr_a) : '0;
        wr_addr_b       = op_active ? ADDR_W'(op.addr_b) : '0;
        valid_transpose = (state_q == WRITE) && op.final_q;
        start_transpose = (state_q == TRANSPOSE);
        busy            = (state_q != IDLE);
        done            = (state_q == DONE);
        q_init          = q_init_q;
    end

endmodule

// File: tb/tb_qr_rotation_sequencer.sv
// Self-checking bench for qr_rotation_sequencer: per-cycle expected outputs are
// built from the rotation schedule rules and a per-op stall plan; the bench
// plays the rotation unit (with optional spurious inputs) and compares on negedge.
module tb_qr_rotation_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0, rot_ready = 1'b0, rot_done = 1'b0;
    logic       rot_valid, rot_mode, wr_en, q_init, valid_transpose, start_transpose, busy, done;
    logic [4:0] rot_addr_a, rot_addr_b, wr_addr_a, wr_addr_b;

    always #5 CLK = ~CLK;

    qr_rotation_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start),
        .rot_valid(rot_valid), .rot_ready(rot_ready), .rot_mode(rot_mode),
        .rot_addr_a(rot_addr_a), .rot_addr_b(rot_addr_b), .rot_done(rot_done),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .q_init(q_init), .valid_transpose(valid_transpose),
        .start_transpose(start_transpose), .busy(busy), .done(done)
    );

    logic [27:0] dut_vec;
    assign dut_vec = {rot_valid, rot_mode, rot_addr_a, rot_addr_b, wr_en, wr_addr_a, wr_addr_b,
                      q_init, valid_transpose, start_transpose, busy, done};

    localparam logic [27:0] M_CTRL  = {1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'b11111};
    localparam logic [27:0] M_ISSUE = M_CTRL | {1'b0, 1'b1, 5'h1f, 5'h1f, 16'd0};
    localparam logic [27:0] M_WR    = M_CTRL | {12'd0, 1'b0, 5'h1f, 5'h1f, 5'd0};
    localparam logic [27:0] M_ALL   = '1;

    function automatic logic [27:0] pk(input logic rv, input logic md, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic we, input logic [4:0] wa,
                                       input logic [4:0] wb, input logic qi, input logic vt,
                                       input logic st, input logic bs, input logic dn);
        return {rv, md, ra, rb, we, wa, wb, qi, vt, st, bs, dn};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { logic md; logic [4:0] a; logic [4:0] b; logic fin; } mop_t;
    typedef struct { logic [27:0] exp; logic [27:0] mask; int rdy; int dn; int op; int ph; bit first; } cyc_t;

    mop_t ops[$];
    cyc_t tr[$];
    int   sr[17];  // extra cycles rot_ready is held low per op
    int   sd[17];  // extra cycles rot_done is delayed per op

    function automatic logic [4:0] ea(input logic bank, input int r, input int c);
        logic [3:0] i;
        i = 4'(r * 3 + c);
        return {bank, i};
    endfunction

    task automatic build_ops();
        int   rp[3], rq[3], rc[3];
        mop_t m;
        rp = '{0, 0, 1}; rq = '{1, 2, 2}; rc = '{0, 0, 1};
        ops.delete();
        for (int r = 0; r < 3; r++) begin
            m.md = 1'b0; m.a = ea(1'b0, rp[r], rc[r]); m.b = ea(1'b0, rq[r], rc[r]); m.fin = 1'b0;
            ops.push_back(m);
            for (int c = rc[r] + 1; c < 3; c++) begin
                m.md = 1'b1; m.a = ea(1'b0, rp[r], c); m.b = ea(1'b0, rq[r], c); m.fin = 1'b0;
                ops.push_back(m);
            end
            for (int c = 0; c < 3; c++) begin
                m.md = 1'b1; m.a = ea(1'b1, rp[r], c); m.b = ea(1'b1, rq[r], c); m.fin = (r == 2);
                ops.push_back(m);
            end
        end
    endtask

    // rdy/dn: 0 or 1 = required input value, 2 = don't care (ignored by DUT)
    task automatic build_trace();
        cyc_t r;
        tr.delete();
        for (int k = 0; k < 17; k++) begin
            for (int s = 0; s <= sr[k]; s++) begin
                r.exp  = pk(1'b1, ops[k].md, ops[k].a, ops[k].b, 1'b0, 5'd0, 5'd0,
                            (k == 0 && s == 0), 1'b0, 1'b0, 1'b1, 1'b0);
                r.mask = M_ISSUE; r.rdy = (s == sr[k]) ? 1 : 0; r.dn = 2;
                r.op = k; r.ph = 0; r.first = (s == 0);
                tr.push_back(r);
            end
            for (int s = 0; s <= sd[k]; s++) begin
                r.exp  = pk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                r.mask = M_CTRL; r.rdy = 2; r.dn = (s == sd[k]) ? 1 : 0;
                r.op = k; r.ph = 1; r.first = (s == 0);
                tr.push_back(r);
            end
            r.exp  = pk(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, ops[k].a, ops[k].b, 1'b0, ops[k].fin,
                        1'b0, 1'b1, 1'b0);
            r.mask = M_WR; r.rdy = 2; r.dn = 2; r.op = k; r.ph = 2; r.first = 1'b1;
            tr.push_back(r);
        end
        for (int t = 0; t < 9; t++) begin
            r.exp  = pk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            r.mask = M_CTRL; r.rdy = 2; r.dn = 2; r.op = -1; r.ph = 3; r.first = (t == 0);
            tr.push_back(r);
        end
        r.exp  = pk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        r.mask = M_CTRL; r.rdy = 2; r.dn = 2; r.op = -1; r.ph = 4; r.first = 1'b1;
        tr.push_back(r);
    endtask

    // noise: 0 = clean rotation unit, 1 = random don't-cares, 2 = all don't-cares high
    function automatic logic pick(input int req, input int noise, input logic clean);
        if (req != 2) return req[0];
        if (noise == 0) return clean;
        if (noise == 1) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    // ---------------- compare process ----------------
    logic [27:0] cur_exp = '0, cur_mask = '0;
    string       cur_nm = "reset";
    int          run_cyc = 0, e_done = 0;
    bit          chk_on = 0, clr = 0, end_flag = 0, pin_on = 0;
    int          n_chk = 0, n_fail = 0;
    int          done_cyc, dn_cnt, busy_cnt, vt_cnt, st_cnt, st_first, st_last;
    logic [9:0]  vt_pair[3];

    task automatic ck(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (run cycle %0d): got 0x%0h, expected 0x%0h", nm, run_cyc, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            if (clr) begin
                done_cyc = -1; dn_cnt = 0; busy_cnt = 0; vt_cnt = 0;
                st_cnt = 0; st_first = -1; st_last = -1;
            end
            ck(cur_nm, 32'(dut_vec & cur_mask), 32'(cur_exp & cur_mask));
            if (done) begin dn_cnt++; done_cyc = run_cyc; end
            if (busy) busy_cnt++;
            if (valid_transpose) begin
                if (vt_cnt < 3) vt_pair[vt_cnt] = {wr_addr_a, wr_addr_b};
                vt_cnt++;
            end
            if (start_transpose) begin
                if (st_first < 0) st_first = run_cyc;
                st_last = run_cyc;
                st_cnt++;
            end
            if (pin_on) begin
                case (run_cyc)
                    1: begin
                        ck("op0_mode", 32'(rot_mode), 32'd0);
                        ck("op0_addr", 32'({rot_addr_a, rot_addr_b}), 32'({5'h00, 5'h03}));
                        ck("op0_q_init", 32'(q_init), 32'd1);
                    end
                    10: begin
                        ck("op3_mode", 32'(rot_mode), 32'd1);
                        ck("op3_addr", 32'({rot_addr_a, rot_addr_b}), 32'({5'h10, 5'h13}));
                    end
                    37: begin
                        ck("op12_mode", 32'(rot_mode), 32'd0);
                        ck("op12_addr", 32'({rot_addr_a, rot_addr_b}), 32'({5'h04, 5'h07}));
                    end
                    default: ;
                endcase
            end
            if (end_flag) begin
                ck("done_cycle", done_cyc, e_done);
                ck("done_pulses", dn_cnt, 1);
                ck("busy_cycles", busy_cnt, e_done);
                ck("vt_pulses", vt_cnt, 3);
                ck("st_cycles", st_cnt, 9);
                ck("st_first", st_first, e_done - 9);
                ck("st_last", st_last, e_done - 1);
                if (pin_on) begin
                    ck("vt_pair0", 32'(vt_pair[0]), 32'({5'h13, 5'h16}));
                    ck("vt_pair1", 32'(vt_pair[1]), 32'({5'h14, 5'h17}));
                    ck("vt_pair2", 32'(vt_pair[2]), 32'({5'h15, 5'h18}));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input string nm, input int noise, input int abort_op, input int exp_done,
                       input bit pin);
        build_trace();
        @(posedge CLK); #1;
        start = 1'b1; rot_ready = pick(2, noise, 1'b1); rot_done = pick(2, noise, 1'b0);
        cur_exp = '0; cur_mask = M_ALL; cur_nm = nm; run_cyc = 0; clr = 1'b1;
        pin_on = pin; e_done = exp_done;
        foreach (tr[i]) begin
            @(posedge CLK); #1;
            clr = 1'b0;
            start     = pick(2, noise, 1'b0);
            rot_ready = pick(tr[i].rdy, noise, 1'b1);
            rot_done  = pick(tr[i].dn, noise, 1'b0);
            cur_exp = tr[i].exp; cur_mask = tr[i].mask; run_cyc = i + 1;
            if (tr[i].op == abort_op && tr[i].ph == 1 && tr[i].first) begin
                RST = 1'b1; start = 1'b1; rot_done = 1'b1;
                @(posedge CLK); #1;
                RST = 1'b0; start = 1'b0; rot_ready = 1'b0; rot_done = 1'b0;
                cur_exp = '0; cur_mask = M_ALL; cur_nm = {nm, "_after_rst"}; run_cyc++;
                @(posedge CLK); #1;
                run_cyc++;
                return;
            end
        end
        @(posedge CLK); #1;
        start = 1'b0; rot_ready = 1'b0; rot_done = 1'b0;
        cur_exp = '0; cur_mask = M_ALL; run_cyc++; end_flag = 1'b1;
        @(posedge CLK); #1;
        end_flag = 1'b0; run_cyc++;
    endtask

    initial begin
        int tot;
        build_ops();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        cur_exp = '0; cur_mask = M_ALL; cur_nm = "reset"; chk_on = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; cur_nm = "idle";
        @(posedge CLK); #1;

        run("min", 0, -1, 61, 1'b1);

        sr[5] = 4; sd[9] = 6;
        run("stall", 0, -1, 71, 1'b0);

        for (int k = 0; k < 17; k++) begin sr[k] = 1; sd[k] = 1; end
        run("spurious", 2, -1, 61 + 34, 1'b0);

        for (int n = 0; n < 4; n++) begin
            tot = 0;
            for (int k = 0; k < 17; k++) begin
                sr[k] = int'($urandom_range(0, 3));
                sd[k] = int'($urandom_range(0, 3));
                tot += sr[k] + sd[k];
            end
            run("random", 1, -1, 61 + tot, 1'b0);
        end

        for (int k = 0; k < 17; k++) begin sr[k] = 0; sd[k] = 0; end
        run("abort", 0, 7, 0, 1'b0);
        run("restart", 0, -1, 61, 1'b1);

        @(posedge CLK); #1;
        start = 1'b1; RST = 1'b1; cur_nm = "start_rst"; cur_exp = '0; cur_mask = M_ALL;
        @(posedge CLK); #1;
        start = 1'b0; RST = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
